// File: rtl/nav_ctrl.sv
// Motion sequencer between the maze solver and the heading PID: runs turn-to-heading
// and forward-move commands, shapes the forward speed and reports completion.
module nav_ctrl #(
  parameter logic [5:0]  FRWRD_INC = 6'h18,
  parameter logic [10:0] MAX_FRWRD = 11'h2A0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        strt_hdng,
  input  logic        strt_mv,
  input  logic        stp_lft,
  input  logic        stp_rght,
  input  logic        hdng_rdy,
  input  logic        at_hdng,
  input  logic        frwrd_opn,
  input  logic        lft_opn,
  input  logic        rght_opn,
  output logic        mv_cmplt,
  output logic        moving,
  output logic        en_fusion,
  output logic [10:0] frwrd_spd
);

  typedef enum logic [2:0] {IDLE, HDNG, RAMP_UP, DEC_NORM, DEC_FAST} state_t;

  state_t      state, state_nxt;
  logic [10:0] spd_nxt;
  logic        cmplt_nxt;
  logic        lft_opn_ff, rght_opn_ff;
  logic        gap_l, gap_r;
  logic [10:0] inc_w, dec_step;
  logic [11:0] inc_sum;
  logic [10:0] spd_up, spd_dn;

  // Side-opening history resets to "open" so an already-open side is not seen as a new gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_opn_ff  <= 1'b1;
      rght_opn_ff <= 1'b1;
    end else begin
      lft_opn_ff  <= lft_opn;
      rght_opn_ff <= rght_opn;
    end
  end

  assign gap_l = lft_opn & ~lft_opn_ff;
  assign gap_r = rght_opn & ~rght_opn_ff;

  always_comb begin
    inc_w    = {5'd0, FRWRD_INC};
    inc_sum  = {1'b0, frwrd_spd} + {1'b0, inc_w};
    spd_up   = (inc_sum > {1'b0, MAX_FRWRD}) ? MAX_FRWRD : inc_sum[10:0];
    dec_step = (state == DEC_FAST) ? (inc_w << 2) : (inc_w << 1);
    spd_dn   = (frwrd_spd > dec_step) ? (frwrd_spd - dec_step) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      frwrd_spd <= '0;
      mv_cmplt  <= 1'b0;
    end else begin
      state     <= state_nxt;
      frwrd_spd <= spd_nxt;
      mv_cmplt  <= cmplt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    spd_nxt   = frwrd_spd;
    cmplt_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (strt_hdng) begin
          state_nxt = HDNG;
        end else if (strt_mv) begin
          state_nxt = RAMP_UP;
          spd_nxt   = '0;
        end
      end
      HDNG: begin
        spd_nxt = '0;
        if (hdng_rdy && at_hdng) begin
          state_nxt = IDLE;
          cmplt_nxt = 1'b1;
        end
      end
      RAMP_UP: begin
        // Wall and gap checks run every clk so single-cycle gap edges are never missed.
        if (!frwrd_opn)
          state_nxt = DEC_FAST;
        else if ((stp_lft && gap_l) || (stp_rght && gap_r))
          state_nxt = DEC_NORM;
        else if (hdng_rdy)
          spd_nxt = spd_up;
      end
      DEC_NORM, DEC_FAST: begin
        if (frwrd_spd == '0) begin
          state_nxt = IDLE;
          cmplt_nxt = 1'b1;
        end else begin
          if (state == DEC_NORM && !frwrd_opn)
            state_nxt = DEC_FAST;
          if (hdng_rdy)
            spd_nxt = spd_dn;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign moving    = (state != IDLE);
  assign en_fusion = (frwrd_spd > {1'b0, MAX_FRWRD[10:1]});

endmodule

// File: tb/tb_nav_ctrl.sv
// Scoreboard bench for nav_ctrl: stimulus queues expected speed changes and completions,
// a negedge monitor compares whenever the DUT changes frwrd_spd or pulses mv_cmplt.
module tb_nav_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        strt_hdng = 1'b0, strt_mv = 1'b0;
  logic        stp_lft = 1'b0, stp_rght = 1'b0;
  logic        hdng_rdy = 1'b0, at_hdng = 1'b0;
  logic        frwrd_opn = 1'b1, lft_opn = 1'b0, rght_opn = 1'b0;
  logic        mv_cmplt, moving, en_fusion;
  logic [10:0] frwrd_spd;

  int checks = 0;
  int errors = 0;
  int cmplt_seen = 0;

  logic [10:0] spd_q[$];
  int          cmplt_q[$];
  logic [10:0] last_spd = '0;

  nav_ctrl #(.FRWRD_INC(6'h18), .MAX_FRWRD(11'h2A0)) dut (
    .clk(clk), .rst_n(rst_n), .strt_hdng(strt_hdng), .strt_mv(strt_mv),
    .stp_lft(stp_lft), .stp_rght(stp_rght), .hdng_rdy(hdng_rdy), .at_hdng(at_hdng),
    .frwrd_opn(frwrd_opn), .lft_opn(lft_opn), .rght_opn(rght_opn),
    .mv_cmplt(mv_cmplt), .moving(moving), .en_fusion(en_fusion), .frwrd_spd(frwrd_spd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: every speed change must match the head of the scoreboard.
  always @(negedge clk) begin
    if (frwrd_spd !== last_spd) begin
      last_spd = frwrd_spd;
      if (spd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL spd_unexpected got %0h expected none at %0t", frwrd_spd, $time);
      end else begin
        logic [10:0] e;
        e = spd_q.pop_front();
        check("frwrd_spd", frwrd_spd, e);
        check("en_fusion", en_fusion, (e > 11'h150) ? 1 : 0);
      end
    end
    if (mv_cmplt === 1'b1) begin
      cmplt_seen++;
      if (cmplt_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL cmplt_unexpected got pulse expected none at %0t", $time);
      end else begin
        int t;
        t = cmplt_q.pop_front();
        check($sformatf("cmplt_spd_t%0d", t), frwrd_spd, 0);
        check($sformatf("cmplt_moving_t%0d", t), moving, 0);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_hdng();
    @(posedge clk); #1 hdng_rdy = 1'b1;
    @(posedge clk); #1 hdng_rdy = 1'b0;
  endtask

  task automatic start(input logic h, input logic m);
    @(posedge clk); #1 strt_hdng = h; strt_mv = m;
    @(posedge clk); #1 strt_hdng = 1'b0; strt_mv = 1'b0;
  endtask

  task automatic ramp(input int n, inout int spd);
    for (int i = 0; i < n; i++) begin
      int nx;
      nx = (spd + 'h18 > 'h2A0) ? 'h2A0 : spd + 'h18;
      if (nx != spd) spd_q.push_back(nx[10:0]);
      spd = nx;
      pulse_hdng();
    end
  endtask

  task automatic decel(input int n, input int step, inout int spd, input int tag);
    for (int i = 0; i < n; i++) begin
      int nx;
      nx = (spd > step) ? spd - step : 0;
      if (nx != spd) spd_q.push_back(nx[10:0]);
      if (nx == 0) cmplt_q.push_back(tag);
      spd = nx;
      pulse_hdng();
    end
  endtask

  initial begin
    int spd;
    int c0;
    #12;
    check("rst_spd", frwrd_spd, 0);
    check("rst_moving", moving, 0);
    check("rst_cmplt", mv_cmplt, 0);
    check("rst_fusion", en_fusion, 0);
    cycles(1); rst_n = 1'b1; cycles(2);

    // 1: heading change completes only when at_hdng seen on a hdng_rdy
    c0 = cmplt_seen;
    start(1'b1, 1'b0);
    check("t1_moving", moving, 1);
    repeat (5) pulse_hdng();
    check("t1_still_moving", moving, 1);
    at_hdng = 1'b1; cycles(3);
    check("t1_no_cmplt_wo_rdy", cmplt_seen - c0, 0);
    cmplt_q.push_back(1);
    pulse_hdng(); at_hdng = 1'b0;
    cycles(3);
    check("t1_moving_done", moving, 0);
    check("t1_cmplt_count", cmplt_seen - c0, 1);
    check("t1_spd", frwrd_spd, 0);

    // 2: ramp to saturation
    spd = 0;
    start(1'b0, 1'b1);
    check("t2_moving", moving, 1);
    ramp(40, spd);
    cycles(2);
    check("t2_sat", frwrd_spd, 'h2A0);

    // 3: wall ahead -> fast decel to stop
    frwrd_opn = 1'b0; cycles(2);
    decel(7, 'h60, spd, 3);
    cycles(4);
    check("t3_moving_done", moving, 0);
    frwrd_opn = 1'b1;

    // 4: left gap stop, ignored right edge, wall mid-decel
    stp_lft = 1'b1;
    start(1'b0, 1'b1);
    ramp(6, spd);
    rght_opn = 1'b1; cycles(3);
    ramp(1, spd);
    lft_opn = 1'b1; cycles(2);
    decel(2, 'h30, spd, 40);
    check("t4_norm_spd", frwrd_spd, 'h48);
    frwrd_opn = 1'b0; cycles(2);
    decel(1, 'h60, spd, 41);
    cycles(4);
    check("t4_moving_done", moving, 0);
    frwrd_opn = 1'b1; stp_lft = 1'b0; lft_opn = 1'b0; rght_opn = 1'b0;
    cycles(2);

    // 5: simultaneous starts -> heading wins
    c0 = cmplt_seen;
    start(1'b1, 1'b1);
    check("t5_moving", moving, 1);
    repeat (2) pulse_hdng();
    check("t5_spd", frwrd_spd, 0);
    at_hdng = 1'b1;
    cmplt_q.push_back(5);
    pulse_hdng(); at_hdng = 1'b0;
    cycles(4);
    check("t5_cmplt_count", cmplt_seen - c0, 1);
    check("t5_moving_done", moving, 0);

    // 6: async reset mid-ramp, side already open at release
    lft_opn = 1'b1; stp_lft = 1'b1; cycles(2);
    start(1'b0, 1'b1);
    ramp(3, spd);
    spd_q.push_back('0);
    @(posedge clk); #3 rst_n = 1'b0; #1;
    check("t6_rst_spd", frwrd_spd, 0);
    check("t6_rst_moving", moving, 0);
    cycles(2);
    rst_n = 1'b1;
    spd = 0;
    start(1'b0, 1'b1);
    ramp(2, spd);
    check("t6_ramping", frwrd_spd, 'h30);
    frwrd_opn = 1'b0; cycles(2);
    decel(1, 'h60, spd, 6);
    cycles(4);
    check("t6_moving_done", moving, 0);

    check("spd_q_empty", spd_q.size(), 0);
    check("cmplt_q_empty", cmplt_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
